// File: rtl/hazard_fwd_unit.sv
// Hazard and forwarding controller for the 5-stage pipeline: operand forwarding
// selects, one-cycle load-use stall, branch flush and a saturating bubble counter.
module hazard_fwd_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic                  id_reg_we,
    input  logic                  id_mem_rd,
    input  logic                  ex_br_taken,
    output logic [1:0]            fwd_sel_a,
    output logic [1:0]            fwd_sel_b,
    output logic                  stall_pc,
    output logic                  stall_ifid,
    output logic                  flush_ifid,
    output logic                  flush_idex,
    output logic [CNT_W-1:0]      bubble_cnt
);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic                  use1;
        logic                  use2;
        logic [REG_ADDR_W-1:0] rd;
        logic                  we;
        logic                  mrd;
    } ex_meta_t;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  we;
        logic                  mrd;
    } mem_meta_t;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  we;
    } wb_meta_t;

    ex_meta_t  ex_q;
    mem_meta_t mem_q;
    wb_meta_t  wb_q;

    logic ex_prod;
    logic mem_prod;
    logic wb_prod;
    logic load_use;
    logic branch;

    // x0 is hardwired, so a write to it never produces a value worth forwarding
    assign ex_prod  = ex_q.valid  & ex_q.we  & (ex_q.rd  != '0);
    assign mem_prod = mem_q.valid & mem_q.we & (mem_q.rd != '0);
    assign wb_prod  = wb_q.valid  & wb_q.we  & (wb_q.rd  != '0);

    assign load_use = ex_prod & ex_q.mrd &
                      ((id_uses_rs1 & (id_rs1 == ex_q.rd)) |
                       (id_uses_rs2 & (id_rs2 == ex_q.rd)));

    // Branch input is gated so every output reads 0 while reset is held
    assign branch = ex_br_taken & rst_n;

    always_comb begin
        flush_ifid = branch;
        flush_idex = branch | load_use;
        stall_pc   = load_use & ~branch;
        stall_ifid = load_use & ~branch;
    end

    always_comb begin
        fwd_sel_a = 2'd0;
        fwd_sel_b = 2'd0;
        if (ex_q.use1 && mem_prod && !mem_q.mrd && (mem_q.rd == ex_q.rs1)) begin
            fwd_sel_a = 2'd1;
        end else if (ex_q.use1 && wb_prod && (wb_q.rd == ex_q.rs1)) begin
            fwd_sel_a = 2'd2;
        end
        if (ex_q.use2 && mem_prod && !mem_q.mrd && (mem_q.rd == ex_q.rs2)) begin
            fwd_sel_b = 2'd1;
        end else if (ex_q.use2 && wb_prod && (wb_q.rd == ex_q.rs2)) begin
            fwd_sel_b = 2'd2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            wb_q.valid  <= mem_q.valid;
            wb_q.rd     <= mem_q.rd;
            wb_q.we     <= mem_q.we;
            mem_q.valid <= ex_q.valid;
            mem_q.rd    <= ex_q.rd;
            mem_q.we    <= ex_q.we;
            mem_q.mrd   <= ex_q.mrd;
            // A bubble also clears its use bits so it can never select a forward
            if (flush_idex) begin
                ex_q <= '0;
            end else begin
                ex_q.valid <= 1'b1;
                ex_q.rs1   <= id_rs1;
                ex_q.rs2   <= id_rs2;
                ex_q.use1  <= id_uses_rs1;
                ex_q.use2  <= id_uses_rs2;
                ex_q.rd    <= id_rd;
                ex_q.we    <= id_reg_we;
                ex_q.mrd   <= id_mem_rd;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt <= '0;
        end else if ((stall_pc | flush_idex) && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule
